uart_tx_serializer: RTL and testbench

//  UART transmit path: accepts a parallel word, emits one serial frame on TX_OUT.

---
 rtl/uart_tx_serializer.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add the PAR_EN/PAR_TYP ports and the PARITY state.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic [5:0]            prescale,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`endif
  output logic                  TX_OUT,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [5:0]            prescale_reg;
  logic [5:0]            bit_cnt;
  logic [IDX_W-1:0]      data_idx;
  logic                  stop_idx;
  logic                  bit_done;
`ifdef UART_TX_PARITY_EN
  logic                  par_en_reg;
  logic                  par_typ_reg;
`endif

  // prescale_reg is never 0 outside IDLE, so prescale_reg-1 is the last count of a bit.
  assign bit_done  = (bit_cnt == (prescale_reg - 6'd1));
  assign state_dbg = state;

  // Handshake: a word is taken on any posedge where DATA_VALID=1 and the FSM is IDLE
  // (busy=0); busy rises on that same edge and DATA_VALID is ignored until busy falls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      TX_OUT       <= 1'b1;
      busy         <= 1'b0;
      data_reg     <= '0;
      shift_reg    <= '0;
      prescale_reg <= '0;
      bit_cnt      <= '0;
      data_idx     <= '0;
      stop_idx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_reg   <= 1'b0;
      par_typ_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          TX_OUT  <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
          if (DATA_VALID) begin
            data_reg     <= P_DATA;
            shift_reg    <= P_DATA;
            prescale_reg <= (prescale == 6'd0) ? 6'd1 : prescale;
`ifdef UART_TX_PARITY_EN
            par_en_reg   <= PAR_EN;
            par_typ_reg  <= PAR_TYP;
`endif
            state        <= S_START;
            TX_OUT       <= 1'b0;
            busy         <= 1'b1;
          end
        end

        S_START: begin
          if (bit_done) begin
            bit_cnt  <= '0;
            data_idx <= '0;
            state    <= S_DATA;
            TX_OUT   <= shift_reg[0];
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end

        S_DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (data_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_reg) begin
                state  <= S_PARITY;
                TX_OUT <= par_typ_reg ? ~^data_reg : ^data_reg;
              end else begin
                state    <= S_STOP;
                stop_idx <= 1'b0;
                TX_OUT   <= 1'b1;
              end
`else
              state    <= S_STOP;
              stop_idx <= 1'b0;
              TX_OUT   <= 1'b1;
`endif
            end else begin
              // Bit 0 was already driven on entry; shift so bit [1] is always the next one.
              data_idx  <= data_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              TX_OUT    <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            bit_cnt  <= '0;
            state    <= S_STOP;
            stop_idx <= 1'b0;
            TX_OUT   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
`endif

        S_STOP: begin
          TX_OUT <= 1'b1;
          if (bit_done) begin
            bit_cnt <= '0;
            if (stop_idx == LAST_STOP) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end

        default: begin
          state   <= S_IDLE;
          TX_OUT  <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench for uart_tx_serializer: per-cycle line/busy compared against a frame model.
module tb_uart_tx_serializer;

  localparam int DW = 8;
  localparam int SB = 1;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic [5:0]    prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          busy;
  logic [2:0]    state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [0:0] exp_q[$];

  uart_tx_serializer #(.DATA_WIDTH(DW), .STOP_BITS(SB)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .prescale   (prescale),
`ifdef UART_TX_PARITY_EN
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
`endif
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the frame as a list of line levels, one entry per CLK cycle.
  task automatic build_frame(input logic [DW-1:0] data, input int presc, input bit pe, input bit pt);
    int p;
    int ones;
    logic [0:0] bits[$];
    p = (presc == 0) ? 1 : presc;
    exp_q.delete();
    bits.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < DW; i++) begin
      bits.push_back(data[i]);
      if (data[i]) ones++;
    end
`ifdef UART_TX_PARITY_EN
    if (pe) bits.push_back((ones % 2 == 1) ? ~pt : pt);
`else
    if (pe && pt) ones = ones;
`endif
    for (int s = 0; s < SB; s++) bits.push_back(1'b1);
    foreach (bits[b])
      for (int c = 0; c < p; c++) exp_q.push_back(bits[b]);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_tx"}, 32'(TX_OUT), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Driver: called at a negedge with the DUT idle. inject_k >= 0 raises DATA_VALID
  // with inj_data during that frame cycle; other cycles scramble P_DATA/prescale/parity.
  task automatic send_frame(input string tag, input logic [DW-1:0] data, input int presc,
                            input bit pe, input bit pt, input int inject_k, input logic [DW-1:0] inj_data);
    int n;
    build_frame(data, presc, pe, pt);
    n = exp_q.size();
    P_DATA = data; prescale = 6'(presc); PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < n; k++) begin
      check_eq({tag, "_tx"}, 32'(TX_OUT), 32'(exp_q[k]));
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      if (k == inject_k) begin
        DATA_VALID = 1'b1; P_DATA = inj_data;
      end else begin
        DATA_VALID = 1'b0;
        P_DATA = DW'($urandom);
        prescale = 6'($urandom_range(0, 63));
        PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      end
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    check_idle({tag, "_end"});
  endtask

  // Start a frame, abort it with an asynchronous reset in cycle abort_k.
  task automatic abort_frame(input logic [DW-1:0] data, input int presc, input int abort_k);
    build_frame(data, presc, 1'b0, 1'b0);
    P_DATA = data; prescale = 6'(presc); PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    for (int k = 0; k < abort_k; k++) begin
      check_eq("pre_abort_tx", 32'(TX_OUT), 32'(exp_q[k]));
      @(negedge CLK);
    end
    #2 RST = 1'b1;
    #1 check_idle("async_rst");
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check_idle("rst_hold");
    end
    RST = 1'b0;
    @(negedge CLK);
    check_idle("post_rst");
    @(negedge CLK);
    check_idle("no_resume");
  endtask

  initial begin
    logic [DW-1:0] d;
    int pr;
    bit pe;
    bit pt;
    RST = 1'b1; DATA_VALID = 1'b0; P_DATA = '0; prescale = 6'd0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #1 check_idle("reset");
    repeat (3) @(negedge CLK);
    check_idle("reset_hold");
    RST = 1'b0;
    @(negedge CLK);
    check_idle("after_reset");

    send_frame("a5_p1", 8'hA5, 1, 1'b0, 1'b0, -1, '0);
    @(negedge CLK);
    send_frame("3c_p16", 8'h3C, 16, 1'b0, 1'b0, -1, '0);
    send_frame("5a_p0", 8'h5A, 0, 1'b0, 1'b0, -1, '0);
    send_frame("00_inj", 8'h00, 2, 1'b0, 1'b0, 5, 8'hFF);
    @(negedge CLK);
    check_idle("no_second_frame");
    abort_frame(8'hC3, 1, 4);
    send_frame("81_after_rst", 8'h81, 1, 1'b0, 1'b0, -1, '0);
`ifdef UART_TX_PARITY_EN
    send_frame("07_even", 8'h07, 1, 1'b1, 1'b0, -1, '0);
    send_frame("07_odd", 8'h07, 1, 1'b1, 1'b1, -1, '0);
    send_frame("07_nopar", 8'h07, 1, 1'b0, 1'b1, -1, '0);
`endif

    // Random frames: back-to-back with one idle cycle, or with a random gap.
    for (int t = 0; t < 30; t++) begin
      d  = DW'($urandom);
      pr = $urandom_range(0, 12);
      pe = 1'($urandom);
      pt = 1'($urandom);
`ifndef UART_TX_PARITY_EN
      pe = 1'b0;
`endif
      send_frame("rand", d, pr, pe, pt,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1, DW'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(negedge CLK);
        check_idle("rand_gap");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
